// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// access-size encodings, FSM state encoding and small address helpers.
package mem_access_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Size 3 falls into the default arm, so it follows the word alignment rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

    // Little-endian byte enables for an aligned access.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 4'b0001 << a;
            SZ_HALF: return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load alignment: picks the addressed byte/half lane out of a
// 32-bit read word and sign- or zero-extends it. Word loads pass through.
module mem_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[gi*8 +: 8];
        end
    endgenerate

    // Lane select then extend; half accesses are aligned so only addr_lo[1] matters.
    always_comb begin
        sel_byte = lane[addr_lo];
        sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        data     = rdata;
        case (size)
            SZ_BYTE: data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
            SZ_HALF: data = {{16{sign_ext & sel_half[15]}}, sel_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit. Passes ALU results straight through,
// runs loads/stores over a req/ready bus with a bounded wait, stalls the
// upstream pipeline while an access is in flight and feeds MEM/WB.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic              in_memRead,
    input  logic              in_memWrite,
    input  logic [1:0]        in_size,
    input  logic              in_signExt,
    input  logic [31:0]       in_aluResult,
    input  logic [31:0]       in_storeData,
    input  logic              in_regWriteEn,
    input  logic [4:0]        in_regWriteAddr,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic              mem_regWriteEn,
    output logic [4:0]        mem_regWriteAddr,
    output logic [31:0]       mem_regWriteData,
    output logic              mem_stall,
    output logic              mem_addrErr,
    output logic              mem_busErr
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [1:0]        alo_q, alo_d;
    logic [4:0]        rwa_q, rwa_d;
    logic              rwe_q, rwe_d;
    logic              load_q, load_d;
    logic [31:0]       ldbuf_q, ldbuf_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic              buserr_q, buserr_d;

    logic              is_memop;
    logic              misaligned;
    logic [31:0]       store_rep;
    logic [31:0]       load_data;

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign mem_busErr = buserr_q;

    mem_load_align u_load_align (
        .rdata    (ldbuf_q),
        .addr_lo  (alo_q),
        .size     (size_q),
        .sign_ext (sext_q),
        .data     (load_data)
    );

    // Decode the incoming op and replicate store data onto every lane it may hit.
    always_comb begin
        is_memop   = in_valid & (in_memRead | in_memWrite);
        misaligned = is_misaligned(in_size, in_aluResult[1:0]);
        case (in_size)
            SZ_BYTE: store_rep = {4{in_storeData[7:0]}};
            SZ_HALF: store_rep = {2{in_storeData[15:0]}};
            default: store_rep = in_storeData;
        endcase
    end

    // Next-state and output logic for the IDLE -> REQ -> RESP access sequence.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        size_d   = size_q;
        sext_d   = sext_q;
        alo_d    = alo_q;
        rwa_d    = rwa_q;
        rwe_d    = rwe_q;
        load_d   = load_q;
        ldbuf_d  = ldbuf_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        buserr_d = 1'b0;

        mem_regWriteEn   = 1'b0;
        mem_regWriteAddr = in_regWriteAddr;
        mem_regWriteData = in_aluResult;
        mem_stall        = 1'b0;
        mem_addrErr      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_memop) begin
                    if (misaligned) begin
                        // Drop the access entirely; the pipeline keeps flowing.
                        mem_addrErr = 1'b1;
                    end else begin
                        mem_stall = 1'b1;
                        req_d     = 1'b1;
                        we_d      = in_memWrite;
                        addr_d    = {in_aluResult[ADDR_W-1:2], 2'b00};
                        wdata_d   = store_rep;
                        be_d      = byte_enable(in_size, in_aluResult[1:0]);
                        size_d    = in_size;
                        sext_d    = in_signExt;
                        alo_d     = in_aluResult[1:0];
                        rwa_d     = in_regWriteAddr;
                        rwe_d     = in_regWriteEn;
                        load_d    = ~in_memWrite;
                        cnt_d     = 8'd0;
                        tmo_d     = 1'b0;
                        state_d   = ST_REQ;
                    end
                end else begin
                    mem_regWriteEn = in_valid & in_regWriteEn;
                end
            end
            ST_REQ: begin
                mem_stall = 1'b1;
                if (dmem_ready) begin
                    req_d   = 1'b0;
                    ldbuf_d = dmem_rdata;
                    cnt_d   = 8'd0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    req_d    = 1'b0;
                    tmo_d    = 1'b1;
                    buserr_d = 1'b1;
                    cnt_d    = 8'd0;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                mem_regWriteEn   = load_q & rwe_q & ~tmo_q;
                mem_regWriteAddr = rwa_q;
                mem_regWriteData = load_data;
                state_d          = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bus registers; reset aborts any outstanding access immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= 4'b0000;
            size_q   <= SZ_BYTE;
            sext_q   <= 1'b0;
            alo_q    <= 2'b00;
            rwa_q    <= 5'd0;
            rwe_q    <= 1'b0;
            load_q   <= 1'b0;
            ldbuf_q  <= 32'd0;
            cnt_q    <= 8'd0;
            tmo_q    <= 1'b0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            size_q   <= size_d;
            sext_q   <= sext_d;
            alo_q    <= alo_d;
            rwa_q    <= rwa_d;
            rwe_q    <= rwe_d;
            load_q   <= load_d;
            ldbuf_q  <= ldbuf_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            buserr_q <= buserr_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT=4). Inputs change and outputs
// are sampled on the falling clock edge, away from the active rising edge.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_memRead, in_memWrite, in_signExt, in_regWriteEn;
    logic [1:0]  in_size;
    logic [31:0] in_aluResult, in_storeData;
    logic [4:0]  in_regWriteAddr;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_regWriteEn, mem_stall, mem_addrErr, mem_busErr;
    logic [4:0]  mem_regWriteAddr;
    logic [31:0] mem_regWriteData;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(4), .ADDR_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_memRead(in_memRead), .in_memWrite(in_memWrite),
        .in_size(in_size), .in_signExt(in_signExt), .in_aluResult(in_aluResult),
        .in_storeData(in_storeData), .in_regWriteEn(in_regWriteEn),
        .in_regWriteAddr(in_regWriteAddr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata),
        .mem_regWriteEn(mem_regWriteEn), .mem_regWriteAddr(mem_regWriteAddr),
        .mem_regWriteData(mem_regWriteData), .mem_stall(mem_stall),
        .mem_addrErr(mem_addrErr), .mem_busErr(mem_busErr)
    );

    task automatic drive_op(input logic v, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic sx,
                            input logic [31:0] alu, input logic [31:0] sd,
                            input logic rwe, input logic [4:0] rwa);
        in_valid = v; in_memRead = rd; in_memWrite = wr; in_size = sz;
        in_signExt = sx; in_aluResult = alu; in_storeData = sd;
        in_regWriteEn = rwe; in_regWriteAddr = rwa;
    endtask

    task automatic drive_idle();
        drive_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0);
    endtask

    task automatic test_reset();
        rstn = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
        drive_idle();
        #2;
        tests++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", dmem_req); end
        tests++; if (dmem_addr !== 32'd0) begin fails++; $display("FAIL rst_addr: got %h want 0", dmem_addr); end
        tests++; if (dmem_be !== 4'd0 || dmem_we !== 1'b0 || dmem_wdata !== 32'd0) begin fails++; $display("FAIL rst_bus: got be=%b we=%b wd=%h want 0", dmem_be, dmem_we, dmem_wdata); end
        tests++; if (mem_stall !== 1'b0 || mem_busErr !== 1'b0 || mem_regWriteEn !== 1'b0) begin fails++; $display("FAIL rst_out: got stall=%b buserr=%b we=%b want 0", mem_stall, mem_busErr, mem_regWriteEn); end
        @(negedge clk); rstn = 1'b1;
        $display("[TB] txn reset done");
    endtask

    task automatic test_alu_pass();
        @(negedge clk);
        drive_op(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'd0, 1'b1, 5'd8);
        #1;
        tests++; if (mem_regWriteEn !== 1'b1 || mem_regWriteAddr !== 5'd8) begin fails++; $display("FAIL alu_we: got we=%b wa=%0d want 1/8", mem_regWriteEn, mem_regWriteAddr); end
        tests++; if (mem_regWriteData !== 32'h1234) begin fails++; $display("FAIL alu_data: got %h want 00001234", mem_regWriteData); end
        tests++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin fails++; $display("FAIL alu_stall: got stall=%b req=%b want 0/0", mem_stall, dmem_req); end
        @(negedge clk);
        drive_op(1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h55, 32'd0, 1'b1, 5'd9);
        #1;
        tests++; if (mem_regWriteEn !== 1'b0) begin fails++; $display("FAIL alu_invalid: got we=%b want 0", mem_regWriteEn); end
        $display("[TB] txn alu_pass done");
    endtask

    task automatic test_lb_wait();
        @(negedge clk);
        drive_op(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h101, 32'd0, 1'b1, 5'd4);
        #1;
        tests++; if (mem_stall !== 1'b1 || dmem_req !== 1'b0) begin fails++; $display("FAIL lb_c1: got stall=%b req=%b want 1/0", mem_stall, dmem_req); end
        @(negedge clk); #1;
        tests++; if (mem_stall !== 1'b1 || dmem_req !== 1'b1 || dmem_we !== 1'b0) begin fails++; $display("FAIL lb_c2: got stall=%b req=%b we=%b want 1/1/0", mem_stall, dmem_req, dmem_we); end
        tests++; if (dmem_be !== 4'b0010 || dmem_addr !== 32'h100) begin fails++; $display("FAIL lb_bus: got be=%b addr=%h want 0010/00000100", dmem_be, dmem_addr); end
        @(negedge clk);
        dmem_ready = 1'b1; dmem_rdata = 32'h0000_8000;
        #1;
        tests++; if (mem_stall !== 1'b1 || dmem_req !== 1'b1) begin fails++; $display("FAIL lb_c3: got stall=%b req=%b want 1/1", mem_stall, dmem_req); end
        @(negedge clk);
        dmem_ready = 1'b0; drive_idle();
        #1;
        tests++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin fails++; $display("FAIL lb_resp: got stall=%b req=%b want 0/0", mem_stall, dmem_req); end
        tests++; if (mem_regWriteEn !== 1'b1 || mem_regWriteAddr !== 5'd4 || mem_regWriteData !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_wb: got we=%b wa=%0d d=%h want 1/4/ffffff80", mem_regWriteEn, mem_regWriteAddr, mem_regWriteData); end
        $display("[TB] txn lb_wait done");
    endtask

    task automatic test_load(input string name, input logic [31:0] addr, input logic [1:0] sz,
                             input logic sx, input logic [31:0] rdata, input logic [31:0] exp_addr,
                             input logic [31:0] exp);
        @(negedge clk);
        drive_op(1'b1, 1'b1, 1'b0, sz, sx, addr, 32'd0, 1'b1, 5'd3);
        #1;
        tests++; if (mem_stall !== 1'b1) begin fails++; $display("FAIL %s_stall: got %b want 1", name, mem_stall); end
        @(negedge clk);
        dmem_ready = 1'b1; dmem_rdata = rdata;
        #1;
        tests++; if (dmem_req !== 1'b1 || dmem_addr !== exp_addr) begin fails++; $display("FAIL %s_req: got req=%b addr=%h want 1/%h", name, dmem_req, dmem_addr, exp_addr); end
        @(negedge clk);
        dmem_ready = 1'b0; drive_idle();
        #1;
        tests++; if (mem_regWriteEn !== 1'b1 || mem_regWriteData !== exp) begin fails++; $display("FAIL %s_wb: got we=%b d=%h want 1/%h", name, mem_regWriteEn, mem_regWriteData, exp); end
        $display("[TB] txn %s done", name);
    endtask

    task automatic test_store(input string name, input logic [31:0] addr, input logic [1:0] sz,
                              input logic [31:0] sd, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd);
        @(negedge clk);
        drive_op(1'b1, 1'b0, 1'b1, sz, 1'b0, addr, sd, 1'b1, 5'd7);
        #1;
        tests++; if (mem_stall !== 1'b1 || mem_regWriteEn !== 1'b0) begin fails++; $display("FAIL %s_c1: got stall=%b we=%b want 1/0", name, mem_stall, mem_regWriteEn); end
        @(negedge clk);
        dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_0000;
        #1;
        tests++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== exp_addr) begin fails++; $display("FAIL %s_req: got req=%b we=%b addr=%h want 1/1/%h", name, dmem_req, dmem_we, dmem_addr, exp_addr); end
        tests++; if (dmem_be !== exp_be || dmem_wdata !== exp_wd) begin fails++; $display("FAIL %s_lanes: got be=%b wd=%h want %b/%h", name, dmem_be, dmem_wdata, exp_be, exp_wd); end
        tests++; if (mem_regWriteEn !== 1'b0) begin fails++; $display("FAIL %s_we_req: got %b want 0", name, mem_regWriteEn); end
        @(negedge clk);
        dmem_ready = 1'b0; drive_idle();
        #1;
        tests++; if (mem_regWriteEn !== 1'b0 || mem_stall !== 1'b0 || dmem_req !== 1'b0) begin fails++; $display("FAIL %s_resp: got we=%b stall=%b req=%b want 0/0/0", name, mem_regWriteEn, mem_stall, dmem_req); end
        $display("[TB] txn %s done", name);
    endtask

    task automatic test_misaligned(input string name, input logic [31:0] addr, input logic [1:0] sz);
        @(negedge clk);
        drive_op(1'b1, 1'b1, 1'b0, sz, 1'b0, addr, 32'd0, 1'b1, 5'd2);
        #1;
        tests++; if (mem_addrErr !== 1'b1 || mem_stall !== 1'b0 || mem_regWriteEn !== 1'b0) begin fails++; $display("FAIL %s_err: got aerr=%b stall=%b we=%b want 1/0/0", name, mem_addrErr, mem_stall, mem_regWriteEn); end
        @(negedge clk);
        drive_idle();
        #1;
        tests++; if (mem_addrErr !== 1'b0 || dmem_req !== 1'b0) begin fails++; $display("FAIL %s_after: got aerr=%b req=%b want 0/0", name, mem_addrErr, dmem_req); end
        $display("[TB] txn %s done", name);
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int err_cycles = 0;
        @(negedge clk);
        dmem_ready = 1'b0;
        drive_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b1, 5'd5);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk); #1;
            if (dmem_req === 1'b1) req_cycles++;
            if (mem_busErr === 1'b1) err_cycles++;
            if (i == 5) begin
                tests++; if (mem_busErr !== 1'b1 || mem_regWriteEn !== 1'b0 || mem_stall !== 1'b0) begin fails++; $display("FAIL tmo_resp: got buserr=%b we=%b stall=%b want 1/0/0", mem_busErr, mem_regWriteEn, mem_stall); end
                drive_idle();
            end
        end
        tests++; if (req_cycles != 4) begin fails++; $display("FAIL tmo_req_cycles: got %0d want 4", req_cycles); end
        tests++; if (err_cycles != 1) begin fails++; $display("FAIL tmo_err_pulse: got %0d want 1", err_cycles); end
        @(negedge clk);
        drive_op(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'hCAFE, 32'd0, 1'b1, 5'd6);
        #1;
        tests++; if (mem_regWriteEn !== 1'b1 || mem_regWriteData !== 32'hCAFE || mem_stall !== 1'b0) begin fails++; $display("FAIL tmo_idle: got we=%b d=%h stall=%b want 1/0000cafe/0", mem_regWriteEn, mem_regWriteData, mem_stall); end
        $display("[TB] txn timeout done");
    endtask

    task automatic test_reset_mid_req();
        @(negedge clk);
        dmem_ready = 1'b0;
        drive_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'd0, 1'b1, 5'd9);
        @(negedge clk); #1;
        tests++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL rmid_req: got %b want 1", dmem_req); end
        rstn = 1'b0; drive_idle();
        #1;
        tests++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin fails++; $display("FAIL rmid_abort: got req=%b stall=%b want 0/0", dmem_req, mem_stall); end
        @(negedge clk); rstn = 1'b1;
        @(negedge clk); #1;
        tests++; if (mem_stall !== 1'b0 || mem_regWriteEn !== 1'b0 || dmem_req !== 1'b0) begin fails++; $display("FAIL rmid_after: got stall=%b we=%b req=%b want 0/0/0", mem_stall, mem_regWriteEn, dmem_req); end
        $display("[TB] txn reset_mid_req done");
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_lb_wait();
        test_store("sh", 32'h202, 2'd1, 32'h0000_ABCD, 32'h200, 4'b1100, 32'hABCD_ABCD);
        test_store("sb", 32'h3,   2'd0, 32'h1234_5678, 32'h0,   4'b1000, 32'h7878_7878);
        test_store("sw", 32'h44,  2'd2, 32'h1234_5678, 32'h44,  4'b1111, 32'h1234_5678);
        test_misaligned("lw_mis", 32'h103, 2'd2);
        test_misaligned("lh_mis", 32'h101, 2'd1);
        test_misaligned("sz3_mis", 32'h102, 2'd3);
        test_load("lbu", 32'h103, 2'd0, 1'b0, 32'h8000_0000, 32'h100, 32'h0000_0080);
        test_load("lh",  32'h102, 2'd1, 1'b1, 32'h8001_1234, 32'h100, 32'hFFFF_8001);
        test_load("lhu", 32'h102, 2'd1, 1'b0, 32'h8001_1234, 32'h100, 32'h0000_8001);
        test_load("lh_lo", 32'h100, 2'd1, 1'b1, 32'h8001_1234, 32'h100, 32'h0000_1234);
        test_timeout();
        test_reset_mid_req();
        test_load("lw_post_rst", 32'h80, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h80, 32'hDEAD_BEEF);
        test_load("lw_sz3", 32'h84, 2'd3, 1'b1, 32'h8765_4321, 32'h84, 32'h8765_4321);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM-stage data-memory access unit. It sits between the EX/MEM pipeline register and the MEM/WB register, and its outputs drive the MEM/WB register's mem_regWriteEn, mem_regWriteAddr and mem_regWriteData inputs. It issues loads and stores to the data memory over a req/ready handshake, aligns and extends load data, and stalls the pipeline while a bus access is outstanding. It also flags misaligned addresses and bus timeouts.

Parameters:
TIMEOUT, 16, maximum cycles REQ may wait for dmem_ready before a bus error (range 1..255).
ADDR_W, 32, data-memory byte-address width.

Ports:
clk  in  1  clock; all state updates on posedge.
rstn  in  1  asynchronous, active-low reset.
in_valid  in  1  EX/MEM holds a valid instruction.
in_memRead  in  1  load instruction.
in_memWrite  in  1  store instruction.
in_size  in  2  access size: 0=byte, 1=half, 2=word; 3 is illegal and treated as word.
in_signExt  in  1  sign-extend load (LB/LH) vs zero-extend (LBU/LHU).
in_aluResult  in  32  effective address for memory ops, or result for ALU ops.
in_storeData  in  32  rt value for stores.
in_regWriteEn  in  1  instruction writes the register file.
in_regWriteAddr  in  5  destination register.
dmem_req  out  1  bus request; held until accepted.
dmem_we  out  1  1=write, 0=read.
dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
dmem_wdata  out  32  lane-replicated store data.
dmem_be  out  4  byte enables (little-endian).
dmem_ready  in  1  bus accepts/completes the request this cycle.
dmem_rdata  in  32  read data, valid when dmem_ready=1 on a read.
mem_regWriteEn  out  1  to MEM/WB.
mem_regWriteAddr  out  5  to MEM/WB.
mem_regWriteData  out  32  to MEM/WB.
mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; insert a bubble-free hold.
mem_addrErr  out  1  one-cycle pulse: misaligned access.
mem_busErr  out  1  one-cycle pulse: bus timeout.

Behaviour:
- Reset (async, rstn=0): state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0; load buffer=0; timeout counter=0; error pulses=0. The combinational outputs then follow the IDLE rules below.
- FSM states: IDLE, REQ, RESP.
- IDLE, non-memory op: mem_regWriteEn = in_valid & in_regWriteEn; data = in_aluResult; mem_stall=0. Zero added latency.
- IDLE, memop (in_valid & (in_memRead|in_memWrite)):
  - Misalignment rule: half with addr[0]=1, or word with addr[1:0]!=0.
  - If misaligned: no request; mem_addrErr=1 for this cycle; mem_regWriteEn=0; mem_stall=0; stay in IDLE.
  - Otherwise: mem_stall=1 combinationally. Posedge: latch dmem_addr, dmem_we, dmem_be, dmem_wdata, size/signExt/addr[1:0]/regWriteAddr; set dmem_req=1; go to REQ.
- Byte enables: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'b1111. Store wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- REQ: mem_stall=1; dmem_req held with all bus outputs stable.
  - On dmem_ready=1: dmem_req=0 next edge, capture dmem_rdata into the load buffer, go to RESP.
  - The counter increments each REQ cycle without ready. When counter==TIMEOUT-1 and no ready: drop dmem_req, pulse mem_busErr, mem_regWriteEn=0 in the following cycle (RESP with a suppressed write), go to RESP.
  - Ready on the final allowed cycle counts as success.
- RESP: mem_stall=0; exactly one cycle; always returns to IDLE.
  - Load: mem_regWriteEn=latched regWriteEn, unless a timeout occurred.
  - Store: mem_regWriteEn=0.
  - Load data: lane select by the latched a[1:0] (half uses a[1]), then sign- or zero-extend per signExt. Word loads pass through.
  - MEM/WB captures at the next edge. Total load/store latency = 2 + (cycles waiting on ready).
- Upstream inputs must stay stable while mem_stall=1. The block samples them only in IDLE.
- Async reset in REQ aborts the access: dmem_req falls immediately and no writeback occurs.
- Illegal size 3: treated as word, including the word alignment rule.

Decomposition:
- Shared package: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the FSM state encoding.
- One natural sub-module, mem_load_align: a combinational lane select plus extend from rdata, a[1:0], size and signExt. It is reused by any future cache path.
- Store lane replication and byte-enable generation stay inline.

Test Plan:
- ALU passthrough: in_valid=1, regWriteEn=1, addr 5'd8, aluResult=32'h1234 -> same cycle mem_regWriteEn=1, data=32'h1234, mem_stall=0.
- LB, signExt=1, addr=32'h101, ready asserted 2nd REQ cycle, rdata=32'h0000_8000 -> mem_stall high 3 cycles, dmem_be=4'b0010, RESP data=32'hFFFF_FF80.
- SH, addr=32'h202, storeData=32'hABCD, ready immediate -> dmem_we=1, dmem_be=4'b1100, dmem_wdata=32'hABCD_ABCD, mem_regWriteEn=0 throughout.
- LW, addr=32'h103 -> mem_addrErr pulse 1 cycle, dmem_req never asserted, mem_regWriteEn=0, no stall.
- LW with dmem_ready held 0, TIMEOUT=4 -> dmem_req high exactly 4 cycles, mem_busErr pulse, no writeback, state returns to IDLE.
- rstn pulsed low mid-REQ -> dmem_req=0 asynchronously, mem_stall=0 after release, next op proceeds normally.
